wave_gen_multi: RTL

Multi-channel, parametrised on/off waveform generator. A shared prescaler produces a time-unit tick, and each of CH channels drives an independent rectangular wave whose high and low phase lengths, in ticks, are set by per-channel inputs. It succeeds the single-channel 4-bit generator and adds:

- a per-channel enable
- defined zero-length behaviour
- a period-start strobe
- optional glitch-free reload of the phase lengths

It sits between register/switch inputs and LED, buzzer or PWM pins on the ElbertV2 board.

---
 rtl/wave_gen_pkg.sv | 14 +
 rtl/wave_gen_channel.sv | 122 ++++++++++++
 rtl/wave_gen_multi.sv | 54 +++++
 3 files changed

// File: rtl/wave_gen_pkg.sv
// Shared types and default constants for the multi-channel on/off waveform generator.
// The optional WAVE_GEN_SHADOW_EN macro is consumed by wave_gen_channel.
package wave_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } wave_state_e;

    localparam int DEFAULT_WIDTH    = 8;
    localparam int DEFAULT_TICK_DIV = 12;

endpackage

// File: rtl/wave_gen_channel.sv
// One waveform channel: IDLE/ON/OFF machine advancing on the shared tick.
// Define WAVE_GEN_SHADOW_EN to latch phase lengths at period start (glitch-free reload).
module wave_gen_channel
    import wave_gen_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             en,
    input  logic [WIDTH-1:0] on_units,
    input  logic [WIDTH-1:0] off_units,
    output logic             wave,
    output logic             period_start
);

    wave_state_e      state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wave_q, wave_d;
    logic             ps_q, ps_d;
    logic [WIDTH-1:0] onLen, offLen;
    logic [WIDTH:0]   cntInc;
    logic             startPeriod;

    assign cntInc = {1'b0, cnt_q} + {{WIDTH{1'b0}}, 1'b1};

`ifdef WAVE_GEN_SHADOW_EN
    logic [WIDTH-1:0] lon_q, lon_d, loff_q, loff_d;

    assign onLen  = lon_q;
    assign offLen = loff_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lon_q  <= '0;
            loff_q <= '0;
        end else begin
            lon_q  <= lon_d;
            loff_q <= loff_d;
        end
    end

    always_comb begin
        lon_d  = lon_q;
        loff_d = loff_q;
        if (startPeriod) begin
            lon_d  = on_units;
            loff_d = off_units;
        end
    end
`else
    assign onLen  = on_units;
    assign offLen = off_units;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wave_q  <= 1'b0;
            ps_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wave_q  <= wave_d;
            ps_q    <= ps_d;
        end
    end

    // A disabled channel drops to IDLE regardless of any coincident tick.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        startPeriod = 1'b0;
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (tick) begin
            case (state_q)
                IDLE: startPeriod = 1'b1;
                ON: begin
                    if (cntInc >= {1'b0, onLen}) begin
                        cnt_d = '0;
                        if (offLen != '0) begin
                            state_d = OFF;
                        end else begin
                            startPeriod = 1'b1;
                        end
                    end else begin
                        cnt_d = cntInc[WIDTH-1:0];
                    end
                end
                OFF: begin
                    if (cntInc >= {1'b0, offLen}) begin
                        startPeriod = 1'b1;
                    end else begin
                        cnt_d = cntInc[WIDTH-1:0];
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
            // The new period's first phase is chosen from the freshly sampled length.
            if (startPeriod) begin
                cnt_d   = '0;
                state_d = (on_units != '0) ? ON : OFF;
            end
        end
    end

    always_comb begin
        wave_d = (state_d == ON);
        ps_d   = startPeriod;
    end

    assign wave         = wave_q;
    assign period_start = ps_q;

endmodule

// File: rtl/wave_gen_multi.sv
// Multi-channel on/off waveform generator: shared prescaler tick feeding CH independent channels.
// Optional WAVE_GEN_SHADOW_EN selects shadowed (period-start sampled) phase lengths.
module wave_gen_multi
    import wave_gen_pkg::*;
#(
    parameter int CH       = 2,
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CH-1:0]       en,
    input  logic [CH*WIDTH-1:0] on_units,
    input  logic [CH*WIDTH-1:0] off_units,
    output logic [CH-1:0]       wave,
    output logic [CH-1:0]       period_start
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    assign tick = (presc_q == LAST);

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : gen_ch
        wave_gen_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .tick        (tick),
            .en          (en[g]),
            .on_units    (on_units[g*WIDTH +: WIDTH]),
            .off_units   (off_units[g*WIDTH +: WIDTH]),
            .wave        (wave[g]),
            .period_start(period_start[g])
        );
    end

endmodule
